cq_eth_arbiter: RTL and testbench
=================================

Name: cq_eth_arbiter

Overview:
- Packet-granular two-input round-robin arbiter on the user_clk domain.
- Merges the PCIe completer-request (CQ) AXI-stream and a local message AXI-stream into the single 64-bit TX stream feeding eth_top.
- Holds the grant from first beat to tlast, registers the output (one-stage slice) and truncates runaway packets.
- Exposes per-source packet counters and a truncation counter for ILA/debug.

Parameters:
- C_DATA_WIDTH, 64, width of all tdata buses.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width (dword granularity).
- USER_WIDTH, 85, tuser width, passed through unmodified.
- MAX_BEATS, 256, maximum beats per forwarded packet (>=2).

Ports:
- user_clk  in  1  clock; all logic is on its rising edge.
- user_reset  in  1  synchronous, active-high reset.
- s0_axis_tdata/tkeep/tuser/tlast/tvalid  in  C_DATA_WIDTH/KEEP_WIDTH/USER_WIDTH/1/1  source 0 (PCIe CQ).
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata/tkeep/tuser/tlast/tvalid  in  same widths  source 1 (local messages).
- s1_axis_tready  out  1  source 1 ready.
- m_axis_tdata/tkeep/tuser/tlast/tvalid  out  same widths  merged stream to eth_top.
- m_axis_tid  out  1  source index of the current output beat.
- m_axis_tready  in  1  downstream ready.
- pkt_cnt0  out  32  packets accepted from s0 (wraps).
- pkt_cnt1  out  32  packets accepted from s1 (wraps).
- trunc_cnt  out  16  truncated packets (saturates at 16'hffff).

Behaviour:
- Reset: state=IDLE; rr pointer=1, so s0 wins the first tie. m_axis_tvalid=0, all other m_axis_* outputs=0, both tready=0, beat counter=0, all counters=0.
- States:
  - IDLE: both treadys=0. If s0 or s1 tvalid, grant the valid one; if both, grant the one != rr. Set rr=grant and move to PASS0 or PASS1 next cycle. This gives exactly one bubble cycle per packet.
  - PASSx: sx_tready = m_axis_tready | ~m_axis_tvalid; the other tready=0. Accepted beat is registered to m_axis_* with m_axis_tid=x.
    - Accepted beat with tlast → increment pkt_cntx, clear beat counter, go to IDLE.
    - Accepted beat without tlast when beat counter == MAX_BEATS-1 → output the beat with tlast forced to 1. Increment pkt_cntx and trunc_cnt (saturating), clear beat counter, go to DRAINx.
  - DRAINx: sx_tready=1, beats are discarded (nothing output). Accepted tlast → IDLE.
- Latency: a beat accepted at cycle t is valid on m_axis at t+1.
- Output stage: m_axis_* holds stable while tvalid=1 and tready=0. Full throughput (one beat/cycle) inside a packet when m_axis_tready=1.
- A packet ending with tlast on exactly beat MAX_BEATS is forwarded normally, not truncated.
- The last beat of a packet may still be in the output register while the FSM is in IDLE/PASS of the next packet. The register slice rule alone prevents overwrite.
- Input tvalid dropping mid-packet: grant is held, no timeout.
- user_reset mid-packet: immediate return to reset values. The in-flight beat is lost; downstream may see a packet without tlast and must be reset in the same domain.
- Counter widths: pkt_cnt wraps 32'hffffffff→0; trunc_cnt sticks at 16'hffff.

Test Plan:
- Single s0 packet, 4 beats, m_axis_tready=1 → m_axis shows 4 beats at 1 beat/cycle, tlast on the 4th, tid=0; pkt_cnt0=1.
- s0 and s1 both continuously offering 2-beat packets → output alternates s0,s1,s0,s1 (first s0 after reset). After 8 packets pkt_cnt0=4 and pkt_cnt1=4, with one bubble between packets.
- m_axis_tready toggling 1010… during a 6-beat s1 packet → no beat lost or duplicated; data held stable while stalled; tid=1 throughout.
- MAX_BEATS=4, s0 sends a 7-beat packet, then a 2-beat packet → output is 4 beats with tlast forced on beat 4, beats 5–7 dropped, then the 2-beat packet intact; trunc_cnt=1, pkt_cnt0=2.
- Packet of exactly 4 beats with MAX_BEATS=4 → forwarded unchanged; trunc_cnt=0.
- user_reset asserted on beat 2 of a 5-beat s1 packet → next cycle m_axis_tvalid=0, both treadys=0, counters=0; the following s1 tie with s0 is granted to s0.

Source files
------------

// File: rtl/cq_eth_arbiter.sv
// rtl/cq_eth_arbiter.sv - packet-granular round-robin merge of two AXI streams with output slice and truncation
module cq_eth_arbiter #(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH/32,
   parameter int USER_WIDTH   = 85,
   parameter int MAX_BEATS    = 256
) (
   input  logic                    user_clk,
   input  logic                    user_reset,

   input  logic [C_DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s0_axis_tkeep,
   input  logic [USER_WIDTH-1:0]   s0_axis_tuser,
   input  logic                    s0_axis_tlast,
   input  logic                    s0_axis_tvalid,
   output logic                    s0_axis_tready,

   input  logic [C_DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s1_axis_tkeep,
   input  logic [USER_WIDTH-1:0]   s1_axis_tuser,
   input  logic                    s1_axis_tlast,
   input  logic                    s1_axis_tvalid,
   output logic                    s1_axis_tready,

   output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tid,
   input  logic                    m_axis_tready,

   output logic [31:0]             pkt_cnt0,
   output logic [31:0]             pkt_cnt1,
   output logic [15:0]             trunc_cnt
);

   localparam int BW = $clog2(MAX_BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

   typedef enum logic [2:0] {IDLE, PASS0, PASS1, DRAIN0, DRAIN1} state_t;

   state_t          state, state_n;
   logic            rr, rr_n;
   logic            pick;
   logic [BW-1:0]   beat_cnt;
   logic            gnt;
   logic            slot_free;
   logic            fwd, close, trunc;

   logic [C_DATA_WIDTH-1:0] sel_tdata;
   logic [KEEP_WIDTH-1:0]   sel_tkeep;
   logic [USER_WIDTH-1:0]   sel_tuser;
   logic                    sel_tlast, sel_tvalid;

   assign gnt        = (state == PASS1) || (state == DRAIN1);
   assign slot_free  = m_axis_tready | ~m_axis_tvalid;
   assign sel_tdata  = gnt ? s1_axis_tdata  : s0_axis_tdata;
   assign sel_tkeep  = gnt ? s1_axis_tkeep  : s0_axis_tkeep;
   assign sel_tuser  = gnt ? s1_axis_tuser  : s0_axis_tuser;
   assign sel_tlast  = gnt ? s1_axis_tlast  : s0_axis_tlast;
   assign sel_tvalid = gnt ? s1_axis_tvalid : s0_axis_tvalid;

   always_comb begin
      state_n        = state;
      rr_n           = rr;
      pick           = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      fwd            = 1'b0;
      close          = 1'b0;
      trunc          = 1'b0;
      case (state)
         IDLE: begin
            // on a tie the source that did not win last time is granted
            if (s0_axis_tvalid | s1_axis_tvalid) begin
               pick    = (s0_axis_tvalid & s1_axis_tvalid) ? ~rr : s1_axis_tvalid;
               rr_n    = pick;
               state_n = pick ? PASS1 : PASS0;
            end
         end
         PASS0, PASS1: begin
            s0_axis_tready = ~gnt & slot_free;
            s1_axis_tready =  gnt & slot_free;
            if (sel_tvalid & slot_free) begin
               fwd = 1'b1;
               if (sel_tlast) begin
                  close   = 1'b1;
                  state_n = IDLE;
               end else if (beat_cnt == LAST_BEAT) begin
                  close   = 1'b1;
                  trunc   = 1'b1;
                  state_n = gnt ? DRAIN1 : DRAIN0;
               end
            end
         end
         DRAIN0, DRAIN1: begin
            s0_axis_tready = ~gnt;
            s1_axis_tready =  gnt;
            if (sel_tvalid & sel_tlast) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state         <= IDLE;
         rr            <= 1'b1;
         beat_cnt      <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tid    <= 1'b0;
         pkt_cnt0      <= '0;
         pkt_cnt1      <= '0;
         trunc_cnt     <= '0;
      end else begin
         state <= state_n;
         rr    <= rr_n;
         if (fwd) beat_cnt <= close ? '0 : beat_cnt + BW'(1);
         if (fwd) begin
            m_axis_tdata  <= sel_tdata;
            m_axis_tkeep  <= sel_tkeep;
            m_axis_tuser  <= sel_tuser;
            m_axis_tlast  <= sel_tlast | trunc;
            m_axis_tid    <= gnt;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (close & ~gnt) pkt_cnt0 <= pkt_cnt0 + 32'd1;
         if (close &  gnt) pkt_cnt1 <= pkt_cnt1 + 32'd1;
         if (trunc && trunc_cnt != 16'hffff) trunc_cnt <= trunc_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_cq_eth_arbiter.sv
// tb/tb_cq_eth_arbiter.sv - self-checking bench for cq_eth_arbiter
module tb_cq_eth_arbiter;

   localparam int DW = 64;
   localparam int KW = 2;
   localparam int UW = 85;
   localparam int MB = 4;

   logic user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   logic          user_reset;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
   logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
   logic          s0_tlast, s0_tvalid, s0_tready;
   logic          s1_tlast, s1_tvalid, s1_tready;
   logic          m_tlast, m_tvalid, m_tid, m_tready;
   logic [31:0]   pkt_cnt0, pkt_cnt1;
   logic [15:0]   trunc_cnt;

   cq_eth_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .MAX_BEATS(MB)) dut (
      .user_clk(user_clk), .user_reset(user_reset),
      .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
      .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
      .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tid(m_tid), .m_axis_tready(m_tready),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
      logic          tid;
   } beat_t;

   typedef struct {
      int l0[4];
      int l1[4];
      int rdy;
      bit gap;
      int c0;
      int c1;
      int tr;
   } scn_t;

   beat_t src0[$], src1[$], expq[$];
   int    idx0, idx1, pkt_no;
   int    n_chk = 0, n_pass = 0;
   int    cyc = 0;
   scn_t  tbl[5];

   always @(posedge user_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   function automatic beat_t mk_beat(input int src, input int pkt, input int b, input bit last);
      beat_t x;
      x.data = {8'(src), 24'(pkt), 16'(b), 16'($urandom)};
      x.keep = KW'($urandom);
      x.user = UW'({$urandom, $urandom, $urandom});
      x.last = last;
      x.tid  = src[0];
      return x;
   endfunction

   task automatic add_pkt(input int src, input int len);
      pkt_no++;
      for (int b = 0; b < len; b++) begin
         if (src == 0) src0.push_back(mk_beat(0, pkt_no, b, b == len - 1));
         else          src1.push_back(mk_beat(1, pkt_no, b, b == len - 1));
      end
   endtask

   // Reference: whole packets alternate between sources that still have work,
   // s0 first; each packet is cut to MB beats with tlast on the last kept beat.
   task automatic build_expected(output int c0, output int c1, output int tr);
      int i0, i1, turn, s, n;
      beat_t b;
      bit    done;
      i0 = 0; i1 = 0; turn = 0; c0 = 0; c1 = 0; tr = 0;
      expq.delete();
      while (i0 < src0.size() || i1 < src1.size()) begin
         if (i0 < src0.size() && i1 < src1.size()) s = turn;
         else s = (i0 < src0.size()) ? 0 : 1;
         n = 0; done = 0;
         while (!done) begin
            if (s == 0) begin b = src0[i0]; i0++; end
            else        begin b = src1[i1]; i1++; end
            n++;
            done = b.last;
            if (n <= MB) begin
               b.last = b.last || (n == MB);
               expq.push_back(b);
            end
         end
         if (s == 0) c0++; else c1++;
         if (n > MB) tr++;
         turn = 1 - s;
      end
   endtask

   task automatic drive(input int rdy_mode, input bit gaps, input int k);
      bit first;
      if (idx0 < src0.size()) begin
         first = (idx0 == 0) || src0[idx0-1].last;
         {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = {src0[idx0].data, src0[idx0].keep, src0[idx0].user, src0[idx0].last};
         s0_tvalid = !gaps || first || ($urandom_range(0, 3) != 0);
      end else s0_tvalid = 1'b0;
      if (idx1 < src1.size()) begin
         first = (idx1 == 0) || src1[idx1-1].last;
         {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = {src1[idx1].data, src1[idx1].keep, src1[idx1].user, src1[idx1].last};
         s1_tvalid = !gaps || first || ($urandom_range(0, 3) != 0);
      end else s1_tvalid = 1'b0;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = (k % 2 == 0);
         default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
   endtask

   task automatic do_reset();
      user_reset = 1'b1;
      s0_tvalid = 0; s1_tvalid = 0; m_tready = 0;
      s0_tdata = 0; s0_tkeep = 0; s0_tuser = 0; s0_tlast = 0;
      s1_tdata = 0; s1_tkeep = 0; s1_tuser = 0; s1_tlast = 0;
      repeat (2) @(posedge user_clk);
      #1 user_reset = 1'b0;
      @(negedge user_clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_treadys", {s0_tready, s1_tready}, 0);
      chk("rst_m_beat", {m_tdata, m_tlast, m_tid}, 0);
      chk("rst_counters", {pkt_cnt0, pkt_cnt1, trunc_cnt}, 0);
      @(posedge user_clk); #1;
      src0.delete(); src1.delete(); expq.delete();
      idx0 = 0; idx1 = 0;
   endtask

   task automatic run(input int rdy_mode, input bit gaps, input bit chk_gap);
      bit    stalled, hs0, hs1, have_prev, prev_last;
      beat_t held, e;
      int    prev_cyc, idle;
      stalled = 0; have_prev = 0; prev_last = 0; prev_cyc = 0; idle = 0;
      drive(rdy_mode, gaps, 0);
      for (int k = 1; k < 3000 && idle <= 4; k++) begin
         @(negedge user_clk);
         if (stalled)
            chk("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast, m_tid},
                {1'b1, held.data, held.keep, held.user, held.last, held.tid});
         if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
               n_chk++;
               $display("FAIL extra_beat: got beat %0h tid %0d, required none", m_tdata, m_tid);
            end else begin
               e = expq.pop_front();
               chk("beat_data", m_tdata, e.data);
               chk("beat_keep_user", {m_tkeep, m_tuser}, {e.keep, e.user});
               chk("beat_last_tid", {m_tlast, m_tid}, {e.last, e.tid});
               if (chk_gap && have_prev) chk("beat_spacing", cyc - prev_cyc, prev_last ? 2 : 1);
               prev_cyc = cyc; prev_last = m_tlast; have_prev = 1;
            end
         end
         stalled = m_tvalid && !m_tready;
         held = '{m_tdata, m_tkeep, m_tuser, m_tlast, m_tid};
         hs0 = s0_tvalid && s0_tready;
         hs1 = s1_tvalid && s1_tready;
         @(posedge user_clk); #1;
         if (hs0) idx0++;
         if (hs1) idx1++;
         if (expq.size() == 0 && idx0 == src0.size() && idx1 == src1.size()) idle++;
         drive(rdy_mode, gaps, k);
      end
      n_chk++;
      if (idle > 4) n_pass++;
      else $display("FAIL scenario_timeout: %0d expected beats left, required 0", expq.size());
      s0_tvalid = 0; s1_tvalid = 0;
   endtask

   initial begin
      int c0, c1, tr, n0, n1;
      tbl[0] = '{'{4,0,0,0}, '{0,0,0,0}, 0, 1'b1, 1, 0, 0};
      tbl[1] = '{'{2,2,2,2}, '{2,2,2,2}, 0, 1'b1, 4, 4, 0};
      tbl[2] = '{'{0,0,0,0}, '{6,3,0,0}, 1, 1'b0, 0, 2, 1};
      tbl[3] = '{'{7,2,0,0}, '{0,0,0,0}, 0, 1'b0, 2, 0, 1};
      tbl[4] = '{'{4,0,0,0}, '{5,1,0,0}, 2, 1'b0, 1, 2, 1};
      pkt_no = 0;

      for (int i = 0; i < 5; i++) begin
         do_reset();
         for (int j = 0; j < 4; j++) begin
            if (tbl[i].l0[j] > 0) add_pkt(0, tbl[i].l0[j]);
            if (tbl[i].l1[j] > 0) add_pkt(1, tbl[i].l1[j]);
         end
         build_expected(c0, c1, tr);
         run(tbl[i].rdy, 1'b0, tbl[i].gap);
         chk("tbl_pkt_cnt0", pkt_cnt0, tbl[i].c0);
         chk("tbl_pkt_cnt1", pkt_cnt1, tbl[i].c1);
         chk("tbl_trunc_cnt", trunc_cnt, tbl[i].tr);
      end

      for (int r = 0; r < 4; r++) begin
         do_reset();
         n0 = $urandom_range(0, 5);
         n1 = $urandom_range(1, 5);
         for (int j = 0; j < 5; j++) begin
            if (j < n0) add_pkt(0, $urandom_range(1, 7));
            if (j < n1) add_pkt(1, $urandom_range(1, 7));
         end
         build_expected(c0, c1, tr);
         run(2, 1'b1, 1'b0);
         chk("rnd_pkt_cnt0", pkt_cnt0, c0);
         chk("rnd_pkt_cnt1", pkt_cnt1, c1);
         chk("rnd_trunc_cnt", trunc_cnt, tr);
      end

      // reset while beat 2 of an s1 packet is being accepted
      do_reset();
      s1_tvalid = 1; s1_tlast = 0; s1_tdata = 64'ha1; m_tready = 1;
      @(posedge user_clk); #1;
      @(posedge user_clk); #1;
      s1_tdata = 64'ha2; user_reset = 1;
      @(negedge user_clk);
      chk("pre_rst_beat", {m_tvalid, m_tid, s1_tready, m_tdata}, {1'b1, 1'b1, 1'b1, 64'ha1});
      @(posedge user_clk); #1;
      @(negedge user_clk);
      chk("mid_rst_m_tvalid", m_tvalid, 0);
      chk("mid_rst_treadys", {s0_tready, s1_tready}, 0);
      chk("mid_rst_counters", {pkt_cnt0, pkt_cnt1, trunc_cnt}, 0);
      @(posedge user_clk); #1;
      user_reset = 0;
      s0_tvalid = 1; s0_tlast = 1; s0_tdata = 64'hb0;
      s1_tlast = 1;
      @(negedge user_clk);
      chk("tie_idle_treadys", {s0_tready, s1_tready}, 0);
      @(posedge user_clk); #1;
      @(negedge user_clk);
      chk("tie_grant_s0", {s0_tready, s1_tready}, 2'b10);
      @(posedge user_clk); #1;
      s0_tvalid = 0; s1_tvalid = 0;
      @(negedge user_clk);
      chk("tie_out_beat", {m_tvalid, m_tid, m_tlast, m_tdata}, {1'b1, 1'b0, 1'b1, 64'hb0});
      chk("tie_pkt_cnt0", pkt_cnt0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
